// File: rtl/rx_packet_saver.sv
// -----------------------------------------------------------------------------
// rx_packet_saver
//
// Purpose:
//   Receive-side counterpart of the packet sender. Sinks Avalon-ST frames from
//   a TSE MAC receive FIFO and writes them word-by-word into packet RAM through
//   an Avalon-MM write master. Once a complete, error-free frame is stored,
//   data_saved is raised and held until the consumer acknowledges.
//
// Ports:
//   clk, reset       MAC rx clock; asynchronous active-high reset
//   rx_*             Avalon-ST sink (data, valid, sop, eop, empty, error, ready)
//   ram_*            Avalon-MM write master (address, writedata, write, waitrequest)
//   data_saved       level: a good frame is stored and not yet acknowledged
//   data_ack         consumer acknowledge (level or pulse), honoured in SAVED only
//   frame_len        byte length of the saved frame, valid while data_saved=1
//   drop_cnt         frames discarded while a saved frame was pending
//   err_cnt          frames rejected (rx_error, oversize, sop without eop)
// -----------------------------------------------------------------------------
module rx_packet_saver #(
    parameter int ADDR_W    = 25,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 380,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       rx_data,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [1:0]        rx_empty,
    input  logic [5:0]        rx_error,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_writedata,
    output logic              ram_write,
    input  logic              ram_waitrequest,
    output logic              data_saved,
    input  logic              data_ack,
    output logic [10:0]       frame_len,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FLUSH,
        DISCARD,
        SAVED
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  widx, widx_next;
    logic [IDX_W-1:0]  wr_idx;
    logic              issue_write;
    logic              ram_write_next;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       wdata_next;
    logic              data_saved_next;
    logic [10:0]       frame_len_next;
    logic [10:0]       len_latch, len_latch_next;
    logic              err_latch, err_latch_next;
    logic              discard_pending, discard_pending_next;
    logic              pending_tmp;
    logic              drop_inc, err_inc;
    logic [CNT_W-1:0]  drop_next, err_next;
    logic              stalled;
    logic              accept;

    // A write is stalled while the slave holds waitrequest. Only states that can
    // issue a new write must stop accepting beats then; the registered write
    // port means a beat is taken in the same cycle the previous write retires.
    assign stalled  = ram_write && ram_waitrequest;
    assign rx_ready = !(stalled && (state == WRITE || state == IDLE));
    assign accept   = rx_valid && rx_ready;

    // Next-state and next-output logic for the whole datapath. A pending write
    // is held by default; any beat that issues a write goes through the shared
    // issue_write path at the bottom so word index, address and eop capture
    // stay consistent between IDLE and WRITE.
    always_comb begin
        state_next           = state;
        widx_next            = widx;
        wr_idx               = '0;
        issue_write          = 1'b0;
        ram_write_next       = stalled;
        addr_next            = ram_address;
        wdata_next           = ram_writedata;
        data_saved_next      = data_saved;
        frame_len_next       = frame_len;
        len_latch_next       = len_latch;
        err_latch_next       = err_latch;
        discard_pending_next = discard_pending;
        pending_tmp          = discard_pending;
        drop_inc             = 1'b0;
        err_inc              = 1'b0;

        case (state)
            IDLE: begin
                if (accept && rx_sop) begin
                    issue_write = 1'b1;
                    wr_idx      = '0;
                    state_next  = WRITE;
                end
            end

            WRITE: begin
                if (accept) begin
                    if (rx_sop) begin
                        // New frame started before the old one ended: count the
                        // broken frame and restart at the first word.
                        err_inc     = 1'b1;
                        issue_write = 1'b1;
                        wr_idx      = '0;
                    end else if (widx == IDX_W'(MAX_WORDS)) begin
                        err_inc    = 1'b1;
                        state_next = rx_eop ? IDLE : DISCARD;
                    end else begin
                        issue_write = 1'b1;
                        wr_idx      = widx;
                    end
                end
            end

            FLUSH: begin
                if (accept && rx_sop) begin
                    drop_inc = 1'b1;
                end
                if (!stalled) begin
                    if (err_latch) begin
                        err_inc    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_len_next       = len_latch;
                        data_saved_next      = 1'b1;
                        discard_pending_next = accept && rx_sop && !rx_eop;
                        state_next           = SAVED;
                    end
                end
            end

            DISCARD: begin
                if (accept && rx_eop) begin
                    state_next = IDLE;
                end
            end

            SAVED: begin
                // Track whether a dropped frame is still in flight so that the
                // remainder is swallowed in DISCARD after the acknowledge.
                if (accept) begin
                    if (rx_sop) begin
                        drop_inc = 1'b1;
                    end
                    if (rx_eop) begin
                        pending_tmp = 1'b0;
                    end else if (rx_sop) begin
                        pending_tmp = 1'b1;
                    end
                end
                if (data_ack) begin
                    data_saved_next      = 1'b0;
                    discard_pending_next = 1'b0;
                    state_next           = pending_tmp ? DISCARD : IDLE;
                end else begin
                    discard_pending_next = pending_tmp;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (issue_write) begin
            ram_write_next = 1'b1;
            addr_next      = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_idx);
            wdata_next     = rx_data;
            widx_next      = wr_idx + 1'b1;
            if (rx_eop) begin
                len_latch_next = 11'({widx_next, 2'b00}) - {9'd0, rx_empty};
                err_latch_next = |rx_error;
                state_next     = FLUSH;
            end
        end

        drop_next = drop_cnt;
        if (drop_inc && drop_cnt != CNT_MAX) begin
            drop_next = drop_cnt + 1'b1;
        end
        err_next = err_cnt;
        if (err_inc && err_cnt != CNT_MAX) begin
            err_next = err_cnt + 1'b1;
        end
    end

    // State and output registers. Reset is asynchronous so a mid-frame reset
    // drops ram_write immediately instead of waiting for the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            widx            <= '0;
            ram_write       <= 1'b0;
            ram_address     <= '0;
            ram_writedata   <= '0;
            data_saved      <= 1'b0;
            frame_len       <= '0;
            len_latch       <= '0;
            err_latch       <= 1'b0;
            discard_pending <= 1'b0;
            drop_cnt        <= '0;
            err_cnt         <= '0;
        end else begin
            state           <= state_next;
            widx            <= widx_next;
            ram_write       <= ram_write_next;
            ram_address     <= addr_next;
            ram_writedata   <= wdata_next;
            data_saved      <= data_saved_next;
            frame_len       <= frame_len_next;
            len_latch       <= len_latch_next;
            err_latch       <= err_latch_next;
            discard_pending <= discard_pending_next;
            drop_cnt        <= drop_next;
            err_cnt         <= err_next;
        end
    end

endmodule

// File: tb/tb_rx_packet_saver.sv
// -----------------------------------------------------------------------------
// tb_rx_packet_saver
//
// Purpose:
//   Directed self-checking bench for rx_packet_saver. A small RAM slave model
//   captures writes (with optional waitrequest stalls) and each test task checks
//   the stored image, frame length, status flag and counters against values
//   computed from the stimulus.
// -----------------------------------------------------------------------------
module tb_rx_packet_saver;

    localparam int ADDR_W = 25;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_sop = 1'b0;
    logic              rx_eop = 1'b0;
    logic [1:0]        rx_empty = '0;
    logic [5:0]        rx_error = '0;
    logic              rx_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_writedata;
    logic              ram_write;
    logic              ram_waitrequest = 1'b0;
    logic              data_saved;
    logic              data_ack = 1'b0;
    logic [10:0]       frame_len;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [0:511];
    int          addr_log [0:511];
    int          wr_count = 0;
    int          wait_n = 0;
    int          stall_cnt = 0;
    int          ready_low_cycles = 0;
    bit          ack_on_sop = 1'b0;

    rx_packet_saver #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(0),
        .MAX_WORDS(380),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_sop(rx_sop),
        .rx_eop(rx_eop),
        .rx_empty(rx_empty),
        .rx_error(rx_error),
        .rx_ready(rx_ready),
        .ram_address(ram_address),
        .ram_writedata(ram_writedata),
        .ram_write(ram_write),
        .ram_waitrequest(ram_waitrequest),
        .data_saved(data_saved),
        .data_ack(data_ack),
        .frame_len(frame_len),
        .drop_cnt(drop_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // RAM slave model: logs completed writes at the edge, then stalls each new
    // write for wait_n cycles by driving waitrequest just after the edge.
    always @(posedge clk) begin
        if (ram_write && !ram_waitrequest) begin
            mem[ram_address[8:0]] = ram_writedata;
            if (wr_count < 512) addr_log[wr_count] = int'(ram_address);
            wr_count++;
            stall_cnt = 0;
        end
        #1;
        if (!ram_write) stall_cnt = 0;
        if (ram_write && stall_cnt < wait_n) begin
            ram_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            ram_waitrequest = 1'b0;
        end
    end

    // Word w of a frame built from bytes seed, seed+1, ...; byte 0 on [31:24].
    function automatic logic [31:0] exp_word(input logic [7:0] seed, input int w);
        logic [7:0] b0;
        b0 = seed + 8'(4 * w);
        return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] empty, input logic [5:0] err);
        int guard;
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_sop   = sop;
        rx_eop   = eop;
        rx_empty = empty;
        rx_error = err;
        if (ack_on_sop && sop) data_ack = 1'b1;
        guard = 0;
        while (!rx_ready && guard < 200) begin
            ready_low_cycles++;
            guard++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_timeout: rx_ready=0 after 200 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        if (ack_on_sop && sop) data_ack = 1'b0;
    endtask

    // Sends up to max_beats beats of an nbytes frame; a complete frame ends
    // with the bus idled at the following falling edge.
    task automatic send_frame(input int nbytes, input logic [7:0] seed,
                              input logic [5:0] err, input int max_beats);
        int nw;
        int empty;
        nw    = (nbytes + 3) / 4;
        empty = nw * 4 - nbytes;
        for (int w = 0; w < nw && w < max_beats; w++) begin
            send_beat(exp_word(seed, w), w == 0, w == nw - 1,
                      (w == nw - 1) ? 2'(empty) : 2'd0,
                      (w == nw - 1) ? err : 6'd0);
        end
        if (max_beats >= nw) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_sop   = 1'b0;
            rx_eop   = 1'b0;
            rx_empty = '0;
            rx_error = '0;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (data_saved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ack_clear: data_saved=%b expected 0", data_saved);
        end
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rx_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: rx_ready=%b expected 1", rx_ready);
        end
        vectors++;
        if (ram_write !== 1'b0 || ram_address !== '0 || ram_writedata !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ram: write=%b addr=%0h data=%h expected all 0",
                     ram_write, ram_address, ram_writedata);
        end
        vectors++;
        if (data_saved !== 1'b0 || frame_len !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: saved=%b len=%0d expected 0/0", data_saved, frame_len);
        end
        vectors++;
        if (drop_cnt !== '0 || err_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: drop=%0d err=%0d expected 0/0", drop_cnt, err_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        int bad;
        wr_count = 0;
        send_frame(64, 8'h10, 6'd0, 1000);
        vectors++;
        if (data_saved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL latency_early: data_saved=%b expected 0 one cycle after eop", data_saved);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (data_saved !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL latency_2cyc: data_saved=%b expected 1 two cycles after eop", data_saved);
        end
        vectors++;
        if (frame_len !== 11'd64) begin
            miscompares++;
            $display("[TB] FAIL basic_len: frame_len=%0d expected 64", frame_len);
        end
        vectors++;
        if (wr_count !== 16) begin
            miscompares++;
            $display("[TB] FAIL basic_writes: count=%0d expected 16", wr_count);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && addr_log[i] != i) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL basic_addr_order: write %0d went to %0d expected %0d", bad, addr_log[bad], bad);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && mem[i] !== exp_word(8'h10, i)) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL basic_image: word %0d=%h expected %h", bad, mem[bad], exp_word(8'h10, bad));
        end
        do_ack();
    endtask

    task automatic test_empty_bytes();
        wr_count = 0;
        send_frame(61, 8'hA0, 6'd0, 1000);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (data_saved !== 1'b1 || frame_len !== 11'd61) begin
            miscompares++;
            $display("[TB] FAIL empty_len: saved=%b len=%0d expected 1/61", data_saved, frame_len);
        end
        vectors++;
        if (wr_count !== 16 || mem[15] !== exp_word(8'hA0, 15)) begin
            miscompares++;
            $display("[TB] FAIL empty_writes: count=%0d last=%h expected 16/%h",
                     wr_count, mem[15], exp_word(8'hA0, 15));
        end
        do_ack();
    endtask

    task automatic test_backpressure();
        int bad;
        int guard;
        wait_n = 3;
        ready_low_cycles = 0;
        wr_count = 0;
        send_frame(64, 8'h55, 6'd0, 1000);
        guard = 0;
        while (data_saved !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        vectors++;
        if (data_saved !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_saved_timeout: data_saved=%b expected 1 within 50 cycles", data_saved);
        end
        vectors++;
        if (ready_low_cycles !== 45) begin
            miscompares++;
            $display("[TB] FAIL bp_ready_low: %0d stalled cycles expected 45", ready_low_cycles);
        end
        vectors++;
        if (wr_count !== 16) begin
            miscompares++;
            $display("[TB] FAIL bp_writes: count=%0d expected 16", wr_count);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && (addr_log[i] != i || mem[i] !== exp_word(8'h55, i))) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL bp_image: write %0d addr=%0d data=%h expected %0d/%h",
                     bad, addr_log[bad], mem[bad], bad, exp_word(8'h55, bad));
        end
        vectors++;
        if (frame_len !== 11'd64) begin
            miscompares++;
            $display("[TB] FAIL bp_len: frame_len=%0d expected 64", frame_len);
        end
        wait_n = 0;
        do_ack();
    endtask

    task automatic test_errors();
        int bad;
        wr_count = 0;
        send_frame(64, 8'h20, 6'h02, 1000);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (data_saved !== 1'b0 || err_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL rxerr_reject: saved=%b err=%0d expected 0/1", data_saved, err_cnt);
        end
        wr_count = 0;
        send_frame(1600, 8'h30, 6'd0, 1000);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wr_count !== 380 || addr_log[379] != 379) begin
            miscompares++;
            $display("[TB] FAIL oversize_writes: count=%0d last_addr=%0d expected 380/379",
                     wr_count, addr_log[379]);
        end
        vectors++;
        if (err_cnt !== 16'd2 || data_saved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oversize_err: err=%0d saved=%b expected 2/0", err_cnt, data_saved);
        end
        wr_count = 0;
        send_frame(64, 8'h40, 6'd0, 1000);
        repeat (2) @(posedge clk);
        #1;
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && mem[i] !== exp_word(8'h40, i)) bad = i;
        vectors++;
        if (data_saved !== 1'b1 || frame_len !== 11'd64 || bad >= 0 || err_cnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL recover_frame: saved=%b len=%0d bad_word=%0d err=%0d expected 1/64/-1/2",
                     data_saved, frame_len, bad, err_cnt);
        end
        do_ack();
    endtask

    task automatic test_drop();
        int bad;
        wr_count = 0;
        send_frame(64, 8'h60, 6'd0, 1000);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (data_saved !== 1'b1 || frame_len !== 11'd64) begin
            miscompares++;
            $display("[TB] FAIL drop_first: saved=%b len=%0d expected 1/64", data_saved, frame_len);
        end
        wr_count = 0;
        send_frame(100, 8'h70, 6'd0, 1000);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (drop_cnt !== 16'd1 || frame_len !== 11'd64 || data_saved !== 1'b1 || wr_count !== 0) begin
            miscompares++;
            $display("[TB] FAIL drop_pending: drop=%0d len=%0d saved=%b writes=%0d expected 1/64/1/0",
                     drop_cnt, frame_len, data_saved, wr_count);
        end
        ack_on_sop = 1'b1;
        send_frame(64, 8'h80, 6'd0, 1000);
        ack_on_sop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (drop_cnt !== 16'd2 || data_saved !== 1'b0 || wr_count !== 0) begin
            miscompares++;
            $display("[TB] FAIL ack_with_sop: drop=%0d saved=%b writes=%0d expected 2/0/0",
                     drop_cnt, data_saved, wr_count);
        end
        send_frame(48, 8'h90, 6'd0, 1000);
        repeat (2) @(posedge clk);
        #1;
        bad = -1;
        for (int i = 0; i < 12; i++) if (bad < 0 && mem[i] !== exp_word(8'h90, i)) bad = i;
        vectors++;
        if (data_saved !== 1'b1 || frame_len !== 11'd48 || bad >= 0 || wr_count !== 12) begin
            miscompares++;
            $display("[TB] FAIL after_drop_frame: saved=%b len=%0d bad_word=%0d writes=%0d expected 1/48/-1/12",
                     data_saved, frame_len, bad, wr_count);
        end
        do_ack();
    endtask

    task automatic test_reset_midframe();
        int bad;
        wr_count = 0;
        send_frame(64, 8'hB0, 6'd0, 7);
        vectors++;
        if (ram_write !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midframe_write: ram_write=%b expected 1 before reset", ram_write);
        end
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        #1;
        vectors++;
        if (ram_write !== 1'b0 || rx_ready !== 1'b1 || data_saved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: write=%b ready=%b saved=%b expected 0/1/0",
                     ram_write, rx_ready, data_saved);
        end
        vectors++;
        if (drop_cnt !== '0 || err_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters_mid: drop=%0d err=%0d expected 0/0", drop_cnt, err_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr_count = 0;
        send_frame(64, 8'hC0, 6'd0, 1000);
        repeat (2) @(posedge clk);
        #1;
        bad = -1;
        for (int i = 0; i < 16; i++) if (bad < 0 && (addr_log[i] != i || mem[i] !== exp_word(8'hC0, i))) bad = i;
        vectors++;
        if (data_saved !== 1'b1 || frame_len !== 11'd64 || wr_count !== 16 || bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL fresh_frame: saved=%b len=%0d writes=%0d bad_word=%0d expected 1/64/16/-1",
                     data_saved, frame_len, wr_count, bad);
        end
        do_ack();
    endtask

    // Scenario sequence; each task leaves the DUT idle with no frame pending.
    initial begin
        test_reset();
        test_basic_frame();
        test_empty_bytes();
        test_backpressure();
        test_errors();
        test_drop();
        test_reset_midframe();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
